sliding_puzzle_core: RTL and testbench
======================================

Name: sliding_puzzle_core

Overview:
Parametrised ROWS x COLS sliding-tile puzzle engine, the successor of the fixed 2x2 board engine. It holds the board as a flat register and tracks the blank cell. It loads a board directly or generates a guaranteed-solvable shuffle from an internal LFSR. In play it applies move commands, counts legal moves and flags a solved board. It sits between the button/debounce logic (status, act, set, random) and the display/VGA renderer (board, blank_pos, win_flag).

Parameters:
ROWS, 2, board rows (>=2)
COLS, 2, board columns (>=2)
SHUF_MOVES, 64, random legal moves applied per shuffle (>=1)
MCW, 10, move counter width
Derived, not overridable: N=ROWS*COLS; TW=$clog2(N) = tile/index width; tile value N-1 is the blank.

Ports:
clk_d  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
game_status  in  2  00 CHOOSE, 01 GAMING, 10 INIT, 11 WON
act  in  4  move request, blank moves: [0] up, [1] right, [2] down, [3] left
set  in  1  CHOOSE-mode load/shuffle strobe
random  in  1  with set: 1 = shuffle, 0 = load load_board
load_board  in  N*TW  board to load; cell i at [i*TW +: TW]
board  out  N*TW  current board; cell i = r*COLS+c, cell 0 is top-left
blank_pos  out  TW  index of the cell holding N-1
move_cnt  out  MCW  legal moves since INIT or shuffle start, saturating
win_flag  out  1  board solved while GAMING
busy  out  1  shuffle in progress
load_err  out  1  one-cycle pulse: rejected load

Behaviour:
- Reset (rst_n low, async) sets:
  - board = solved (cell i = i); blank_pos = N-1.
  - move_cnt = 0; win_flag = 0; busy = 0; load_err = 0.
  - LFSR = 16'hACE1.
- Reset mid-shuffle aborts the shuffle immediately.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle after reset, in all modes.
- Legality at blank (r,c):
  - up needs r>0 (partner i-COLS); down needs r<ROWS-1 (partner i+COLS).
  - left needs c>0 (partner i-1); right needs c<COLS-1 (partner i+1).
- A move swaps the blank cell with its partner and sets blank_pos to the partner index. All updates take effect on the same edge.
- CHOOSE, busy=0, set=1, random=0:
  - Scan load_board; blank = lowest index holding N-1.
  - If found: board<=load_board, blank_pos<=that index.
  - If not found: board unchanged, load_err=1 for one cycle.
  - Permutation validity is otherwise not checked.
- CHOOSE, busy=0, set=1, random=1, start edge k:
  - board<=solved, blank_pos<=N-1, move_cnt<=0, busy<=1, shuffle counter<=SHUF_MOVES.
  - On each edge k+1..k+SHUF_MOVES, one move is applied. Direction = LFSR[1:0] (0 up, 1 right, 2 down, 3 left). If illegal, the opposite direction is used, which is always legal because ROWS,COLS>=2.
  - busy drops on edge k+SHUF_MOVES, so it is high for exactly SHUF_MOVES cycles.
  - The result is always solvable.
- While busy:
  - act, set and game_status are ignored; the shuffle completes regardless of mode.
  - move_cnt is not incremented; win_flag is forced 0.
- INIT: move_cnt<=0, win_flag<=0; board and blank_pos hold.
- GAMING, busy=0:
  - act priority is [0]>[1]>[2]>[3]; only the highest set bit is considered.
  - Legal move: swap, and move_cnt increments, saturating at 2^MCW-1.
  - Illegal or no request: everything holds.
  - act is level-sensitive: one move per cycle while held. Upstream delivers single-cycle pulses.
- WON and CHOOSE without set: board, blank_pos and move_cnt hold.
- win_flag is registered every edge as (board==solved) & (game_status==GAMING) & ~busy, evaluated on the pre-edge board.
  - It rises one cycle after the solving move.
  - It falls on the first edge where status is not GAMING.

Test Plan:
- Reset, ROWS=COLS=2 (TW=2) -> board=8'hE4, blank_pos=3, move_cnt=0, win_flag=0, busy=0.
- CHOOSE, set=1, random=0, load_board=8'h9C -> next cycle board=8'h9C, blank_pos=1. Then load_board=8'h00 -> load_err high one cycle, board stays 8'h9C.
- GAMING from 8'h9C, blank_pos=1:
  - act=4'b0001 (up, illegal at r=0) -> no change, move_cnt=0.
  - act=4'b0100 (down) -> board=8'hD8, blank_pos=3, move_cnt=1.
  - act=4'b0101 -> up wins priority.
- Load 8'hB4 (blank_pos=2), GAMING, act=4'b0010 -> board=8'hE4, blank_pos=3, move_cnt=1; win_flag=1 one cycle later. Status to WON -> board held, win_flag=0 next cycle.
- ROWS=COLS=3, SHUF_MOVES=32, set&random in CHOOSE:
  - busy high exactly 32 cycles and act ignored.
  - Final board is a permutation of 0..8, and board[blank_pos]==8.
  - Repeat with rst_n pulsed low at cycle 10 -> all outputs at reset values immediately.
- MCW=4, GAMING, 20 alternating legal right/left moves on 2x2 -> move_cnt saturates at 15. INIT -> move_cnt=0.

Source files
------------

// File: rtl/sliding_puzzle_core.sv
// Sliding-tile puzzle engine for a ROWS x COLS board.
// The board is kept as a flat register of TW-bit tiles, and tile value N-1 is the blank.
// The engine loads a board directly or builds a solvable shuffle by playing
// random legal moves driven by a free-running LFSR.
// In play it applies one move per cycle, counts legal moves and reports a solved board.
`timescale 1ns/1ps
module sliding_puzzle_core #(
  parameter int ROWS       = 2,
  parameter int COLS       = 2,
  parameter int SHUF_MOVES = 64,
  parameter int MCW        = 10,
  localparam int N  = ROWS * COLS,
  localparam int TW = $clog2(N)
) (
  input  logic            clk_d,
  input  logic            rst_n,
  input  logic [1:0]      game_status,
  input  logic [3:0]      act,
  input  logic            set,
  input  logic            random,
  input  logic [N*TW-1:0] load_board,
  output logic [N*TW-1:0] board,
  output logic [TW-1:0]   blank_pos,
  output logic [MCW-1:0]  move_cnt,
  output logic            win_flag,
  output logic            busy,
  output logic            load_err
);

  localparam int SCW = $clog2(SHUF_MOVES + 1);

  localparam logic [1:0] ST_CHOOSE = 2'b00;
  localparam logic [1:0] ST_GAMING = 2'b01;
  localparam logic [1:0] ST_INIT   = 2'b10;

  localparam logic [TW-1:0] BLANK = TW'(N - 1);

  function automatic logic [N*TW-1:0] solved_board();
    logic [N*TW-1:0] b;
    b = '0;
    for (int i = 0; i < N; i++) b[i*TW +: TW] = TW'(i);
    return b;
  endfunction

  localparam logic [N*TW-1:0] SOLVED = solved_board();

  // Returns {legal, partner index} for moving the blank at pos in direction dir
  // (0 up, 1 right, 2 down, 3 left). The partner equals pos when illegal.
  function automatic logic [TW:0] step_to(input logic [TW-1:0] pos, input logic [1:0] dir);
    int  p, r, c, q;
    logic ok;
    p  = int'(pos);
    r  = p / COLS;
    c  = p % COLS;
    ok = 1'b0;
    q  = p;
    case (dir)
      2'd0: begin ok = (r > 0);        q = p - COLS; end
      2'd1: begin ok = (c < COLS - 1); q = p + 1;    end
      2'd2: begin ok = (r < ROWS - 1); q = p + COLS; end
      default: begin ok = (c > 0);     q = p - 1;    end
    endcase
    if (!ok) q = p;
    return {ok, TW'(q)};
  endfunction

  logic [N*TW-1:0] board_q, board_d;
  logic [TW-1:0]   blank_q, blank_d;
  logic [MCW-1:0]  move_cnt_q, move_cnt_d;
  logic            win_q, win_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic [SCW-1:0]  shuf_q, shuf_d;
  logic [15:0]     lfsr_q, lfsr_d;

  logic            do_move;
  logic [TW-1:0]   partner;
  logic [TW:0]     st;
  logic [1:0]      dir;
  logic            found;
  logic [TW-1:0]   found_idx;

  // Next-state logic: shuffle sequencing, loads, play moves, counters and win detection.
  always_comb begin
    board_d    = board_q;
    blank_d    = blank_q;
    move_cnt_d = move_cnt_q;
    win_d      = (board_q == SOLVED) && (game_status == ST_GAMING) && !busy_q;
    busy_d     = busy_q;
    err_d      = 1'b0;
    shuf_d     = shuf_q;
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    do_move    = 1'b0;
    partner    = blank_q;
    st         = '0;
    dir        = 2'd0;
    found      = 1'b0;
    found_idx  = '0;

    if (busy_q) begin
      // A random direction that hits an edge is flipped; the opposite move is always legal.
      st = step_to(blank_q, lfsr_q[1:0]);
      if (!st[TW]) st = step_to(blank_q, lfsr_q[1:0] ^ 2'd2);
      do_move = 1'b1;
      partner = st[TW-1:0];
      shuf_d  = shuf_q - 1'b1;
      if (shuf_q == SCW'(1)) busy_d = 1'b0;
    end else begin
      case (game_status)
        ST_CHOOSE: begin
          if (set) begin
            if (random) begin
              board_d    = SOLVED;
              blank_d    = BLANK;
              move_cnt_d = '0;
              busy_d     = 1'b1;
              shuf_d     = SCW'(SHUF_MOVES);
            end else begin
              // Scanning downwards leaves the lowest index that holds the blank.
              for (int i = N - 1; i >= 0; i--) begin
                if (load_board[i*TW +: TW] == BLANK) begin
                  found     = 1'b1;
                  found_idx = TW'(i);
                end
              end
              if (found) begin
                board_d = load_board;
                blank_d = found_idx;
              end else begin
                err_d = 1'b1;
              end
            end
          end
        end
        ST_GAMING: begin
          if (|act) begin
            if (act[0])      dir = 2'd0;
            else if (act[1]) dir = 2'd1;
            else if (act[2]) dir = 2'd2;
            else             dir = 2'd3;
            st = step_to(blank_q, dir);
            if (st[TW]) begin
              do_move = 1'b1;
              partner = st[TW-1:0];
              if (move_cnt_q != '1) move_cnt_d = move_cnt_q + 1'b1;
            end
          end
        end
        ST_INIT: move_cnt_d = '0;
        default: ;
      endcase
    end

    if (do_move) begin
      board_d[int'(blank_q)*TW +: TW] = board_q[int'(partner)*TW +: TW];
      board_d[int'(partner)*TW +: TW] = board_q[int'(blank_q)*TW +: TW];
      blank_d = partner;
    end
  end

  // State registers; reset restores the solved board and aborts any shuffle.
  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      board_q    <= SOLVED;
      blank_q    <= BLANK;
      move_cnt_q <= '0;
      win_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      shuf_q     <= '0;
      lfsr_q     <= 16'hACE1;
    end else begin
      board_q    <= board_d;
      blank_q    <= blank_d;
      move_cnt_q <= move_cnt_d;
      win_q      <= win_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      shuf_q     <= shuf_d;
      lfsr_q     <= lfsr_d;
    end
  end

  assign board     = board_q;
  assign blank_pos = blank_q;
  assign move_cnt  = move_cnt_q;
  assign win_flag  = win_q;
  assign busy      = busy_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_sliding_puzzle_core.sv
// Bench for sliding_puzzle_core: directed scenarios plus randomized play
// against a row/column reference model of the puzzle rules.
`timescale 1ns/1ps
module tb_sliding_puzzle_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_n_b;

  // A: 2x2 default, B: 3x3 SHUF_MOVES=32, C: 2x2 MCW=4
  logic [1:0] st_a, st_b, st_c;
  logic [3:0] act_a, act_b, act_c;
  logic set_a, set_b, set_c, rnd_a, rnd_b, rnd_c;
  logic [7:0] ld_a, ld_c, brd_a, brd_c;
  logic [35:0] ld_b, brd_b;
  logic [1:0] blk_a, blk_c;
  logic [3:0] blk_b;
  logic [9:0] cnt_a, cnt_b;
  logic [3:0] cnt_c;
  logic win_a, win_b, win_c, busy_a, busy_b, busy_c, err_a, err_b, err_c;

  sliding_puzzle_core u_a (
    .clk_d(clk), .rst_n(rst_n), .game_status(st_a), .act(act_a), .set(set_a), .random(rnd_a),
    .load_board(ld_a), .board(brd_a), .blank_pos(blk_a), .move_cnt(cnt_a), .win_flag(win_a),
    .busy(busy_a), .load_err(err_a));

  sliding_puzzle_core #(.ROWS(3), .COLS(3), .SHUF_MOVES(32), .MCW(10)) u_b (
    .clk_d(clk), .rst_n(rst_n_b), .game_status(st_b), .act(act_b), .set(set_b), .random(rnd_b),
    .load_board(ld_b), .board(brd_b), .blank_pos(blk_b), .move_cnt(cnt_b), .win_flag(win_b),
    .busy(busy_b), .load_err(err_b));

  sliding_puzzle_core #(.ROWS(2), .COLS(2), .SHUF_MOVES(64), .MCW(4)) u_c (
    .clk_d(clk), .rst_n(rst_n), .game_status(st_c), .act(act_c), .set(set_c), .random(rnd_c),
    .load_board(ld_c), .board(brd_c), .blank_pos(blk_c), .move_cnt(cnt_c), .win_flag(win_c),
    .busy(busy_c), .load_err(err_c));

  int errors = 0;
  int checks = 0;

  // Reference model state (one board at a time)
  int mrows, mcols, mn, mtw, mmcw;
  int mcell[16];
  int mblank, mcnt;
  bit mwin, merr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic m_init(input int r, input int c, input int mcw);
    mrows = r; mcols = c; mn = r * c; mmcw = mcw;
    mtw = 0;
    while ((1 << mtw) < mn) mtw++;
    for (int i = 0; i < 16; i++) mcell[i] = i;
    mblank = mn - 1; mcnt = 0; mwin = 0; merr = 0;
  endtask

  function automatic logic [63:0] m_pack();
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < mn; i++) p = p | (64'(mcell[i]) << (i * mtw));
    return p;
  endfunction

  // One clock of the puzzle rules, outside any shuffle.
  task automatic m_clock(input int st, input logic [3:0] ac, input bit s, input bit r, input logic [63:0] ld);
    bit solved;
    int d, row, col, tgt, found, v, tmp, cmax;
    solved = 1;
    for (int i = 0; i < mn; i++) if (mcell[i] != i) solved = 0;
    merr = 0;
    cmax = (1 << mmcw) - 1;
    if (st == 0 && s && !r) begin
      found = -1;
      for (int i = mn - 1; i >= 0; i--) begin
        v = int'((ld >> (i * mtw)) & ((64'd1 << mtw) - 1));
        if (v == mn - 1) found = i;
      end
      if (found >= 0) begin
        for (int i = 0; i < mn; i++) mcell[i] = int'((ld >> (i * mtw)) & ((64'd1 << mtw) - 1));
        mblank = found;
      end else merr = 1;
    end else if (st == 1 && ac != 0) begin
      d = 0;
      while (!ac[d]) d++;
      row = mblank / mcols; col = mblank % mcols; tgt = -1;
      if (d == 0 && row > 0) tgt = mblank - mcols;
      if (d == 1 && col < mcols - 1) tgt = mblank + 1;
      if (d == 2 && row < mrows - 1) tgt = mblank + mcols;
      if (d == 3 && col > 0) tgt = mblank - 1;
      if (tgt >= 0) begin
        tmp = mcell[tgt]; mcell[tgt] = mcell[mblank]; mcell[mblank] = tmp;
        mblank = tgt;
        mcnt = (mcnt < cmax) ? mcnt + 1 : cmax;
      end
    end else if (st == 2) begin
      mcnt = 0;
    end
    mwin = solved && (st == 1);
  endtask

  task automatic drive(input int which, input logic [1:0] st, input logic [3:0] ac, input logic s,
                       input logic r, input logic [63:0] ld);
    if (which == 0) begin
      st_a = st; act_a = ac; set_a = s; rnd_a = r; ld_a = ld[7:0];
    end else begin
      st_b = st; act_b = ac; set_b = s; rnd_b = r; ld_b = ld[35:0];
    end
  endtask

  task automatic sample(input int which, output logic [63:0] gb, output logic [63:0] gblk,
                        output logic [63:0] gcnt, output logic gwin, output logic gerr);
    if (which == 0) begin
      gb = 64'(brd_a); gblk = 64'(blk_a); gcnt = 64'(cnt_a); gwin = win_a; gerr = err_a;
    end else begin
      gb = 64'(brd_b); gblk = 64'(blk_b); gcnt = 64'(cnt_b); gwin = win_b; gerr = err_b;
    end
  endtask

  function automatic logic [35:0] solved36();
    logic [35:0] b;
    b = '0;
    for (int i = 0; i < 9; i++) b[i*4 +: 4] = 4'(i);
    return b;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; rst_n_b = 1'b0;
    drive(0, 2'b00, 4'b0, 1'b0, 1'b0, 64'd0);
    drive(1, 2'b00, 4'b0, 1'b0, 1'b0, 64'd0);
    st_c = 2'b00; act_c = 4'b0; set_c = 1'b0; rnd_c = 1'b0; ld_c = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; rst_n_b = 1'b1;
    checks++; if (brd_a !== 8'hE4) begin errors++; $display("FAIL reset_board: got %h want e4", brd_a); end
    checks++; if (blk_a !== 2'd3) begin errors++; $display("FAIL reset_blank: got %0d want 3", blk_a); end
    checks++; if (cnt_a !== 10'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt_a); end
    checks++; if (win_a !== 1'b0) begin errors++; $display("FAIL reset_win: got %b want 0", win_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_a); end
    checks++; if (brd_b !== solved36()) begin errors++; $display("FAIL reset_board3x3: got %h want %h", brd_b, solved36()); end
    checks++; if (blk_b !== 4'd8) begin errors++; $display("FAIL reset_blank3x3: got %0d want 8", blk_b); end
    step();
    checks++; if (brd_a !== 8'hE4) begin errors++; $display("FAIL choose_hold: got %h want e4", brd_a); end
  endtask

  task automatic test_load();
    drive(0, 2'b00, 4'b0, 1'b1, 1'b0, 64'h9C);
    step();
    checks++; if (brd_a !== 8'h9C) begin errors++; $display("FAIL load_board: got %h want 9c", brd_a); end
    checks++; if (blk_a !== 2'd1) begin errors++; $display("FAIL load_blank: got %0d want 1", blk_a); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL load_noerr: got %b want 0", err_a); end
    drive(0, 2'b00, 4'b0, 1'b1, 1'b0, 64'h00);
    step();
    checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL load_err_pulse: got %b want 1", err_a); end
    checks++; if (brd_a !== 8'h9C) begin errors++; $display("FAIL load_err_hold: got %h want 9c", brd_a); end
    drive(0, 2'b00, 4'b0, 1'b0, 1'b0, 64'h00);
    step();
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL load_err_clear: got %b want 0", err_a); end
  endtask

  task automatic test_moves();
    drive(0, 2'b01, 4'b0001, 1'b0, 1'b0, 64'h00);
    step();
    checks++; if (brd_a !== 8'h9C || cnt_a !== 10'd0) begin errors++; $display("FAIL illegal_up: board %h cnt %0d want 9c 0", brd_a, cnt_a); end
    drive(0, 2'b01, 4'b0100, 1'b0, 1'b0, 64'h00);
    step();
    checks++; if (brd_a !== 8'hD8) begin errors++; $display("FAIL down_board: got %h want d8", brd_a); end
    checks++; if (blk_a !== 2'd3 || cnt_a !== 10'd1) begin errors++; $display("FAIL down_blank_cnt: blank %0d cnt %0d want 3 1", blk_a, cnt_a); end
    drive(0, 2'b01, 4'b0101, 1'b0, 1'b0, 64'h00);
    step();
    checks++; if (brd_a !== 8'h9C || blk_a !== 2'd1 || cnt_a !== 10'd2) begin errors++; $display("FAIL priority_up: board %h blank %0d cnt %0d want 9c 1 2", brd_a, blk_a, cnt_a); end
    drive(0, 2'b01, 4'b0000, 1'b0, 1'b0, 64'h00);
    step();
    checks++; if (brd_a !== 8'h9C || cnt_a !== 10'd2) begin errors++; $display("FAIL idle_hold: board %h cnt %0d want 9c 2", brd_a, cnt_a); end
  endtask

  task automatic test_win();
    drive(0, 2'b00, 4'b0, 1'b1, 1'b0, 64'hB4);
    step();
    checks++; if (blk_a !== 2'd2) begin errors++; $display("FAIL win_load_blank: got %0d want 2", blk_a); end
    drive(0, 2'b10, 4'b0, 1'b0, 1'b0, 64'h00);
    step();
    checks++; if (cnt_a !== 10'd0) begin errors++; $display("FAIL init_clear: got %0d want 0", cnt_a); end
    drive(0, 2'b01, 4'b0010, 1'b0, 1'b0, 64'h00);
    step();
    checks++; if (brd_a !== 8'hE4 || blk_a !== 2'd3 || cnt_a !== 10'd1) begin errors++; $display("FAIL solve_move: board %h blank %0d cnt %0d want e4 3 1", brd_a, blk_a, cnt_a); end
    checks++; if (win_a !== 1'b0) begin errors++; $display("FAIL win_early: got %b want 0", win_a); end
    drive(0, 2'b01, 4'b0000, 1'b0, 1'b0, 64'h00);
    step();
    checks++; if (win_a !== 1'b1) begin errors++; $display("FAIL win_rise: got %b want 1", win_a); end
    drive(0, 2'b11, 4'b0000, 1'b0, 1'b0, 64'h00);
    step();
    checks++; if (win_a !== 1'b0 || brd_a !== 8'hE4) begin errors++; $display("FAIL won_fall: win %b board %h want 0 e4", win_a, brd_a); end
  endtask

  task automatic test_random_play(input int which, input int cycles);
    logic [63:0] ld, gb, gblk, gcnt;
    logic gwin, gerr;
    logic [1:0] st;
    logic [3:0] ac;
    logic s;
    int sel, j, tmp;
    int perm[16];
    if (which == 0) m_init(2, 2, 10); else m_init(3, 3, 10);
    drive(which, 2'b00, 4'b0, 1'b1, 1'b0, m_pack());
    step();
    drive(which, 2'b10, 4'b0, 1'b0, 1'b0, 64'd0);
    step();
    for (int k = 0; k < cycles; k++) begin
      sel = $urandom_range(0, 9);
      ac = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      s = 1'b0; ld = '0;
      if (sel <= 5) st = 2'b01;
      else if (sel == 6) st = 2'b10;
      else if (sel == 7) st = 2'b11;
      else st = 2'b00;
      if (sel == 9) begin
        s = 1'b1;
        for (int i = 0; i < mn; i++) perm[i] = i;
        for (int i = mn - 1; i > 0; i--) begin
          j = $urandom_range(0, i); tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        if ($urandom_range(0, 3) == 0)
          for (int i = 0; i < mn; i++) if (perm[i] == mn - 1) perm[i] = 0;
        for (int i = 0; i < mn; i++) ld = ld | (64'(perm[i]) << (i * mtw));
      end
      drive(which, st, ac, s, 1'b0, ld);
      step();
      m_clock(int'(st), ac, s, 1'b0, ld);
      sample(which, gb, gblk, gcnt, gwin, gerr);
      checks++; if (gb !== m_pack()) begin errors++; $display("FAIL rnd_board[%0d] cyc %0d: got %h want %h", which, k, gb, m_pack()); end
      checks++; if (gblk !== 64'(mblank)) begin errors++; $display("FAIL rnd_blank[%0d] cyc %0d: got %0d want %0d", which, k, gblk, mblank); end
      checks++; if (gcnt !== 64'(mcnt)) begin errors++; $display("FAIL rnd_cnt[%0d] cyc %0d: got %0d want %0d", which, k, gcnt, mcnt); end
      checks++; if (gwin !== mwin) begin errors++; $display("FAIL rnd_win[%0d] cyc %0d: got %b want %b", which, k, gwin, mwin); end
      checks++; if (gerr !== merr) begin errors++; $display("FAIL rnd_err[%0d] cyc %0d: got %b want %b", which, k, gerr, merr); end
    end
    drive(which, 2'b00, 4'b0, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic test_shuffle();
    int busy_cycles;
    bit seen[9];
    bit ok;
    int v;
    drive(1, 2'b00, 4'b0, 1'b1, 1'b1, 64'd0);
    step();
    busy_cycles = 0;
    if (busy_b === 1'b1) busy_cycles++;
    checks++; if (brd_b !== solved36() || blk_b !== 4'd8 || cnt_b !== 10'd0) begin errors++; $display("FAIL shuf_start: board %h blank %0d cnt %0d", brd_b, blk_b, cnt_b); end
    for (int k = 0; k < 100; k++) begin
      drive(1, 2'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), {$urandom, $urandom});
      step();
      if (busy_b !== 1'b1) break;
      busy_cycles++;
      checks++; if (win_b !== 1'b0 || cnt_b !== 10'd0) begin errors++; $display("FAIL shuf_busy_state: win %b cnt %0d want 0 0", win_b, cnt_b); end
    end
    drive(1, 2'b00, 4'b0, 1'b0, 1'b0, 64'd0);
    checks++; if (busy_cycles != 32) begin errors++; $display("FAIL shuf_busy_len: got %0d want 32", busy_cycles); end
    ok = 1;
    for (int i = 0; i < 9; i++) seen[i] = 0;
    for (int i = 0; i < 9; i++) begin
      v = int'(brd_b[i*4 +: 4]);
      if (v > 8 || seen[v]) ok = 0; else seen[v] = 1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL shuf_perm: board %h is not a permutation", brd_b); end
    checks++; if (brd_b[int'(blk_b)*4 +: 4] !== 4'd8) begin errors++; $display("FAIL shuf_blank: cell %0d holds %0d want 8", blk_b, brd_b[int'(blk_b)*4 +: 4]); end
    checks++; if (cnt_b !== 10'd0) begin errors++; $display("FAIL shuf_cnt: got %0d want 0", cnt_b); end
  endtask

  task automatic test_shuffle_reset();
    drive(1, 2'b00, 4'b0, 1'b1, 1'b1, 64'd0);
    step();
    drive(1, 2'b01, 4'b0100, 1'b0, 1'b0, 64'd0);
    repeat (9) step();
    checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL shufrst_busy_before: got %b want 1", busy_b); end
    rst_n_b = 1'b0;
    #1;
    checks++; if (busy_b !== 1'b0 || win_b !== 1'b0 || err_b !== 1'b0) begin errors++; $display("FAIL shufrst_flags: busy %b win %b err %b want 0 0 0", busy_b, win_b, err_b); end
    checks++; if (brd_b !== solved36() || blk_b !== 4'd8 || cnt_b !== 10'd0) begin errors++; $display("FAIL shufrst_board: board %h blank %0d cnt %0d", brd_b, blk_b, cnt_b); end
    drive(1, 2'b00, 4'b0, 1'b0, 1'b0, 64'd0);
    step();
    rst_n_b = 1'b1;
    repeat (2) step();
    checks++; if (busy_b !== 1'b0 || brd_b !== solved36()) begin errors++; $display("FAIL shufrst_aborted: busy %b board %h", busy_b, brd_b); end
  endtask

  task automatic test_saturate();
    int exp_cnt;
    st_c = 2'b01;
    for (int k = 1; k <= 20; k++) begin
      act_c = (k % 2 == 1) ? 4'b1000 : 4'b0010;
      step();
      exp_cnt = (k < 15) ? k : 15;
      checks++; if (cnt_c !== 4'(exp_cnt) || blk_c !== ((k % 2 == 1) ? 2'd2 : 2'd3)) begin errors++; $display("FAIL sat_move %0d: cnt %0d blank %0d want %0d", k, cnt_c, blk_c, exp_cnt); end
    end
    act_c = 4'b0; st_c = 2'b10;
    step();
    checks++; if (cnt_c !== 4'd0) begin errors++; $display("FAIL sat_init: got %0d want 0", cnt_c); end
    st_c = 2'b00;
  endtask

  initial begin
    test_reset();
    test_load();
    test_moves();
    test_win();
    test_random_play(0, 300);
    test_random_play(1, 300);
    test_shuffle();
    test_shuffle_reset();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
